row_clear_engine: RTL and testbench
===================================

# row_clear_engine

Post-landing line-clear stage for the Tetris playfield. It sits between the piece-landing logic, which merges the falling shape into the board canvas, and the red-pixel layer fed to the LED matrix driver. On a start pulse it captures the board, removes every full playfield row, compacts the remaining rows downward, zero-fills the top, and returns the new board with a count of cleared lines.

## Interface
Parameters:
- ROWS, 16, number of board rows; row 0 is the top, row ROWS-1 is the bottom.
- ROW_MASK, 16'h03FC, playfield column bits (9..2). A row is full when `(row & ROW_MASK) == ROW_MASK`.

Ports:
- clkSelect  in  1  game-domain clock (divided board clock).
- reset  in  1  reset, synchronous, active-high; clock clkSelect.
- start  in  1  request; sampled only in IDLE.
- board_in  in  [ROWS-1:0][15:0]  board after piece merge; captured on the accepted start.
- busy  out  1  high while a request is in progress.
- done  out  1  single-cycle completion pulse.
- board_out  out  [ROWS-1:0][15:0]  compacted board; registered; holds until the next done.
- lines_cleared  out  5  number of full rows removed by the last request (0..ROWS); holds.
- score  out  10  running cleared-line total (see Configuration).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: when start=1, capture board_in into src, clear work buffer to 0, set rd=ROWS-1, wr=ROWS-1, cnt=0, go to SCAN.
- SCAN: process one row per cycle, src[rd].
  - Full row: discard it; cnt<=cnt+1.
  - Otherwise: work[wr]<=src[rd]; wr<=wr-1.
  - After processing rd==0, go to DONE. Otherwise rd<=rd-1.
- DONE: board_out<=work, lines_cleared<=cnt, done=1, return to IDLE.
- Bits outside ROW_MASK are copied unchanged with their row. They never make a row full.
- Rows above the last written row stay 0, so vacated top rows are empty.
- Full rows need not be contiguous. Relative order of kept rows is preserved.
- start while busy: ignored, not queued.
- Empty board: output equals input (all zero); lines_cleared=0.
- All rows full: board_out all zero; lines_cleared=ROWS.
- Counters: rd and wr are 4 bits for ROWS=16 and do not wrap during a valid scan. wr is not decremented below 0; when every row is kept, the final write lands at wr=0.

## Timing
- Reset values: busy=0, done=0, board_out=0, lines_cleared=0, score=0, state=IDLE.
- start sampled at edge T (IDLE). SCAN occupies edges T+1..T+ROWS. The DONE state is entered at edge T+ROWS.
- done is high for exactly the cycle following edge T+ROWS. Within that cycle the new board_out and lines_cleared are already visible (registered at that edge), giving latency ROWS+1 cycles from the start edge.
- busy is high from edge T through the done cycle inclusive. Earliest re-accept is the edge after done.
- reset mid-SCAN: at the next edge all outputs take their reset values, the partial result is discarded, and no done is produced.
- reset and start together: reset wins.

## Configuration
- Macro ROW_CLEAR_SCORE_EN.
- Defined: at each done, score <= min(score + lines_cleared, 1023). score saturates at 1023 and is cleared only by reset.
- Undefined: score is tied to 0 and no accumulator register is built. All other behaviour is identical.

## Test plan
- Reset, then start with board_in all 0 -> done exactly 17 cycles after the start edge; board_out=0; lines_cleared=0; busy high for those 17 cycles.
- Row15=16'h03FC, row14=16'h0010, other rows 0 -> board_out row15=16'h0010, rows 0..14=0; lines_cleared=1.
- Rows 15 and 13 = 16'hFFFF, row14=16'h0104, row12=16'h0200 -> row15=16'h0104, row14=16'h0200, other rows 0; lines_cleared=2.
- Row15=16'h03F8 (one cell missing), bit 1 set in all rows -> no row cleared; board_out=board_in; lines_cleared=0.
- Second start pulsed 5 cycles into a scan -> ignored; exactly one done. Then assert reset at SCAN cycle 8 of a new request -> no done, board_out=0, busy=0.
- With ROW_CLEAR_SCORE_EN: three requests clearing 4, 2, 0 lines -> score 4, 6, 6. Preload by repetition to 1022, then clear 4 -> score 1023. Without the macro -> score stays 0 throughout.

Source files
------------

// File: rtl/row_clear_engine.sv
// row_clear_engine: removes full playfield rows from a captured board and compacts the rest downward.
// Optional ROW_CLEAR_SCORE_EN builds a saturating running total of cleared lines on score.
module row_clear_engine #(
    parameter int          ROWS     = 16,
    parameter logic [15:0] ROW_MASK = 16'h03FC
) (
    input  logic                  clkSelect,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROWS-1:0][15:0] board_in,
    output logic                  busy,
    output logic                  done,
    output logic [ROWS-1:0][15:0] board_out,
    output logic [4:0]            lines_cleared,
    output logic [9:0]            score
);
    localparam int AW = $clog2(ROWS);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state_q, state_d;
    logic [ROWS-1:0][15:0] src_q, src_d, work_q, work_d, board_out_q, board_out_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [4:0] cnt_q, cnt_d, lines_cleared_q, lines_cleared_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [15:0] row;
    logic full, last;
    always_comb begin
        row = src_q[rd_q];
        full = (row & ROW_MASK) == ROW_MASK;
        last = state_q == SCAN && rd_q == '0;
        state_d = state_q;
        src_d = src_q;
        work_d = work_q;
        board_out_d = board_out_q;
        rd_d = rd_q;
        wr_d = wr_q;
        cnt_d = cnt_q;
        lines_cleared_d = lines_cleared_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                src_d = board_in;
                work_d = '0;
                rd_d = AW'(ROWS - 1);
                wr_d = AW'(ROWS - 1);
                cnt_d = '0;
                busy_d = 1'b1;
            end
            SCAN: begin
                if (full) cnt_d = cnt_q + 5'd1;
                else begin
                    work_d[wr_q] = row;
                    wr_d = wr_q == '0 ? wr_q : wr_q - 1'b1;
                end
                // The last row's result goes straight to the outputs so done sees it.
                if (last) begin
                    state_d = DONE;
                    board_out_d = work_d;
                    lines_cleared_d = cnt_d;
                    done_d = 1'b1;
                end else rd_d = rd_q - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clkSelect) begin
        if (reset) begin
            state_q <= IDLE;
            src_q <= '0;
            work_q <= '0;
            board_out_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            lines_cleared_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q <= src_d;
            work_q <= work_d;
            board_out_q <= board_out_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            lines_cleared_q <= lines_cleared_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign board_out = board_out_q;
    assign lines_cleared = lines_cleared_q;
`ifdef ROW_CLEAR_SCORE_EN
    logic [9:0] score_q, score_d;
    logic [10:0] sum;
    always_comb begin
        sum = {1'b0, score_q} + {6'd0, lines_cleared_d};
        score_d = last ? (sum > 11'd1023 ? 10'd1023 : sum[9:0]) : score_q;
    end
    always_ff @(posedge clkSelect) begin
        if (reset) score_q <= '0;
        else score_q <= score_d;
    end
    assign score = score_q;
`else
    assign score = '0;
`endif
endmodule

// File: tb/tb_row_clear_engine.sv
// tb_row_clear_engine: directed boards with a queue of expected results checked whenever done fires.
module tb_row_clear_engine;
    typedef logic [15:0][15:0] board_t;
    logic clkSelect = 1'b0;
    logic reset = 1'b1, start = 1'b0, busy, done;
    board_t board_in = '0, board_out;
    logic [4:0] lines_cleared;
    logic [9:0] score;
    int checks = 0, failures = 0, dones = 0, exp_score = 0;
    board_t exp_b[$];
    logic [4:0] exp_l[$];

    always #5 clkSelect = ~clkSelect;

    row_clear_engine dut (
        .clkSelect(clkSelect), .reset(reset), .start(start), .board_in(board_in),
        .busy(busy), .done(done), .board_out(board_out),
        .lines_cleared(lines_cleared), .score(score)
    );

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clkSelect) begin
        if (done === 1'b1) begin
            dones++;
            if (exp_b.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                chk("board_out", board_out, exp_b.pop_front());
                chk("lines_cleared", lines_cleared, exp_l.pop_front());
            end
        end
    end

    task automatic run(input board_t b, input board_t eb, input logic [4:0] el, input int poke);
        int n, bcnt;
        @(negedge clkSelect);
        board_in = b;
        start = 1'b1;
        exp_b.push_back(eb);
        exp_l.push_back(el);
`ifdef ROW_CLEAR_SCORE_EN
        exp_score = exp_score + el > 1023 ? 1023 : exp_score + el;
`endif
        @(negedge clkSelect);
        start = 1'b0;
        n = 1;
        bcnt = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bcnt++;
            start = n == poke;
            if (n == poke) board_in = '1;
            @(negedge clkSelect);
            n++;
        end
        start = 1'b0;
        if (busy === 1'b1) bcnt++;
        chk("latency", n, 17);
        chk("busy_cycles", bcnt, 17);
        @(negedge clkSelect);
        chk("idle_after_done", {busy, done}, 0);
        chk("score", score, exp_score);
    endtask

    task automatic do_reset();
        @(negedge clkSelect);
        reset = 1'b1;
        @(negedge clkSelect);
        @(negedge clkSelect);
        reset = 1'b0;
        exp_score = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        board_t b, e;
        int d0;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_board", board_out, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_score", score, 0);

        run('0, '0, 5'd0, 0);

        b = '0; b[15] = 16'h03FC; b[14] = 16'h0010;
        e = '0; e[15] = 16'h0010;
        run(b, e, 5'd1, 0);

        b = '0; b[15] = 16'hFFFF; b[14] = 16'h0104; b[13] = 16'hFFFF; b[12] = 16'h0200;
        e = '0; e[15] = 16'h0104; e[14] = 16'h0200;
        run(b, e, 5'd2, 0);

        b = {16{16'h0002}}; b[15] = 16'h03FA;
        run(b, b, 5'd0, 0);

        run('1, '0, 5'd16, 0);

        b = {16{16'h03FC}}; b[0] = 16'h0001;
        e = '0; e[15] = 16'h0001;
        run(b, e, 5'd15, 0);

        b = '0; b[15] = 16'hFC03; b[3] = 16'h03FC;
        e = '0; e[15] = 16'hFC03;
        d0 = dones;
        run(b, e, 5'd1, 5);
        repeat (25) @(negedge clkSelect);
        chk("ignored_start_dones", dones - d0, 1);

        d0 = dones;
        board_in = '0;
        start = 1'b1;
        @(negedge clkSelect);
        start = 1'b0;
        repeat (8) @(negedge clkSelect);
        reset = 1'b1;
        @(negedge clkSelect);
        reset = 1'b0;
        exp_score = 0;
        chk("midscan_busy", busy, 0);
        chk("midscan_board", board_out, 0);
        chk("midscan_lines", lines_cleared, 0);
        chk("midscan_score", score, 0);
        repeat (25) @(negedge clkSelect);
        chk("midscan_no_done", dones - d0, 0);

        board_in = '1;
        reset = 1'b1;
        start = 1'b1;
        @(negedge clkSelect);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        repeat (25) @(negedge clkSelect);
        chk("rst_start_no_done", dones - d0, 0);

        b = '0; b[15] = 16'h03FC; b[14] = 16'h03FC; b[13] = 16'h03FC; b[12] = 16'h03FC; b[11] = 16'h0400;
        e = '0; e[15] = 16'h0400;
        run(b, e, 5'd4, 0);
        board_in = '0;
        b = '0; b[15] = 16'hFFFF; b[14] = 16'hFFFF; b[13] = 16'h0008;
        e = '0; e[15] = 16'h0008;
        run(b, e, 5'd2, 0);
        b = '0; b[15] = 16'h0104;
        run(b, b, 5'd0, 0);
        b = '0; b[15] = 16'h03FC; b[14] = 16'h03FC; b[13] = 16'h03FC; b[12] = 16'h03FC; b[11] = 16'h0400;
        e = '0; e[15] = 16'h0400;
        repeat (256) run(b, e, 5'd4, 0);
`ifdef ROW_CLEAR_SCORE_EN
        chk("score_saturated", score, 1023);
`else
        chk("score_disabled", score, 0);
`endif
        chk("queue_empty", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
